timer_regressivo: RTL and testbench
===================================

Name: timer_regressivo

Overview:
Countdown timer, the down-counting counterpart of the cron stopwatch. It loads a preset in seconds and counts down once per second while play_pause is high. It stops at zero and pulses done for one cycle. It sits beside cron in the cronometro design and uses the same 50 MHz clock and the same play_pause semantics.

Parameters:
DIV, 50000000, clock cycles per tick (50 MHz -> 1 Hz); must be >= 2; benches override it with a small value.
WIDTH, 10, width of preset and q.

Ports:
clk  input  1  system clock, all logic on posedge.
rst_n  input  1  reset, synchronous, active-low.
play_pause  input  1  level: 1 = count, 0 = hold.
load  input  1  synchronous load strobe.
preset  input  WIDTH  value to load, unsigned seconds.
q  output  WIDTH  remaining seconds, registered.
tick_1s  output  1  one-cycle pulse at each divider wrap.
running  output  1  high while in state RUN.
done  output  1  one-cycle pulse when q reaches 0 by counting.

Behaviour:
- Reset: clk and rst_n as decided above (one clock; reset synchronous, active-low). With rst_n=0 at a posedge: q=0, divider=0, tick_1s=0, done=0, running=0, state=IDLE. Reset overrides load and play_pause.
- States:
  - IDLE: q==0; play_pause ignored; divider held at 0.
  - PAUSED: q!=0, divider frozen.
  - RUN: divider advancing.
  - EXPIRED: lasts one cycle; done=1.
- Priority, highest first: reset > load > count/pause logic.
- load=1 at an edge:
  - q<=preset, divider<=0, done<=0.
  - Next state: IDLE if preset==0; RUN if play_pause=1; otherwise PAUSED.
  - Applies in any state, including RUN and EXPIRED.
- PAUSED -> RUN at the edge where play_pause=1. RUN -> PAUSED at the edge where play_pause=0; the divider does not advance at that edge.
- The divider keeps its value across pause, so the fractional second is preserved.
- In RUN, the divider counts 0..DIV-1 and wraps to 0. At the wrap edge, tick_1s=1 for that cycle and q<=q-1.
- Expiry: a wrap with q==1 gives q<=0, state<=EXPIRED, done<=1, running<=0, all at the same edge. EXPIRED -> IDLE on the next edge, and done returns to 0.
- q never underflows; no ticks occur outside RUN.
- Load at the same edge as an expiry wrap: load wins, done stays 0, q=preset.
- Latency: a load followed by continuous play_pause=1 gives the first tick DIV cycles after the load edge.
- Divider width is $clog2(DIV). All arithmetic is unsigned, width WIDTH.

Decomposition:
- Shared include cron_defs.vh: state encodings (IDLE=2'd0, PAUSED=2'd1, RUN=2'd2, EXPIRED=2'd3) and default DIV.
- One sub-module, divisor_en: enable-gated, synchronously clearable modulo-DIV counter that outputs the tick pulse. The FSM and q register remain in timer_regressivo.

Test Plan (DIV=4):
- Reset: rst_n=0 for 3 clocks with load=1, preset=7 -> q=0, running=0, done=0, tick_1s=0 throughout.
- Full countdown: load preset=3 with play_pause=1 -> tick_1s every 4 cycles; q goes 3,2,1,0; done high exactly 1 cycle at the edge 12 cycles after load, together with q=0 and running falling; no further ticks afterwards.
- Pause/resume: preset=5, run 6 cycles (q=4, divider=2), then play_pause=0 for 10 cycles -> q holds 4, no tick. Set play_pause=1 -> next tick after 2 cycles, q=3.
- Reload mid-run: at q=3 with divider=3, load preset=2 -> q=2 at the next edge, no tick at that edge, first tick 4 cycles later. A load on the expiry edge -> q=preset, done never asserts.
- Zero preset: load preset=0 with play_pause=1 -> state IDLE, running=0, no tick, no done for 20 cycles.
- Reset mid-run: rst_n=0 for one edge at q=3 -> q=0, running=0, and the next count needs a new load.

Source files
------------

// File: rtl/timer_regressivo_pkg.sv
// Shared definitions for the countdown timer: state encoding and default sizing.
package timer_regressivo_pkg;

  // 50 MHz system clock -> one tick per second
  localparam int unsigned DIV_DEFAULT   = 50_000_000;
  localparam int unsigned WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSED  = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/timer_regressivo_divisor_en.sv
// Enable-gated, synchronously clearable modulo-DIV counter.
// wrap is the combinational "this edge wraps" strobe; tick is its registered copy.
module divisor_en #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign wrap = en && !clr && (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 while enabled; clear wins over enable; count holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      tick <= wrap;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_regressivo.sv
// Countdown timer: loads a preset in seconds and counts down once per
// divider wrap while play_pause is high, pulsing done when it reaches zero.
module timer_regressivo
  import timer_regressivo_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_pause,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] q,
  output logic             tick_1s,
  output logic             running,
  output logic             done
);

  state_t state, state_nxt;
  logic   div_en;
  logic   wrap;

  // Divider advances whenever a nonzero count is present and play_pause is
  // high, so the resume edge itself advances it and the pause edge does not.
  assign div_en = play_pause && !load && ((state == RUN) || (state == PAUSED));

  divisor_en #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (div_en),
    .wrap  (wrap),
    .tick  (tick_1s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; load overrides everything below reset
  always_comb begin
    state_nxt = state;
    if (load) begin
      if (preset == '0)    state_nxt = IDLE;
      else if (play_pause) state_nxt = RUN;
      else                 state_nxt = PAUSED;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        PAUSED,
        RUN: begin
          if (!play_pause)                      state_nxt = PAUSED;
          else if (wrap && (q == WIDTH'(1)))    state_nxt = EXPIRED;
          else                                  state_nxt = RUN;
        end
        EXPIRED: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    running = (state == RUN);
    done    = (state == EXPIRED);
  end

  // Remaining-seconds register: load, else decrement on each divider wrap
  always_ff @(posedge clk) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= preset;
    else if (wrap) q <= q - WIDTH'(1);
  end

endmodule

// File: tb/tb_timer_regressivo.sv
// Scoreboard bench for timer_regressivo: the driver pushes the expected
// post-edge outputs from a seconds/phase model; the monitor pops and compares.
module tb_timer_regressivo;

  localparam int unsigned TB_DIV = 4;
  localparam int unsigned W      = 10;

  logic         clk = 1'b0;
  logic         rst_n, play_pause, load;
  logic [W-1:0] preset;
  logic [W-1:0] q;
  logic         tick_1s, running, done;

  always #5 clk = ~clk;

  timer_regressivo #(
    .DIV   (TB_DIV),
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_pause (play_pause),
    .load       (load),
    .preset     (preset),
    .q          (q),
    .tick_1s    (tick_1s),
    .running    (running),
    .done       (done)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         tick;
    logic         running;
    logic         done;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model: seconds remaining and cycles elapsed inside the current second
  int unsigned m_q     = 0;
  int unsigned m_phase = 0;

  task automatic step(input logic r, input logic ld, input logic pp, input logic [W-1:0] pre);
    exp_t e;
    rst_n      = r;
    load       = ld;
    play_pause = pp;
    preset     = pre;
    e.tick = 1'b0;
    e.done = 1'b0;
    if (!r) begin
      m_q     = 0;
      m_phase = 0;
    end else if (ld) begin
      m_q     = pre;
      m_phase = 0;
    end else if (m_q != 0 && pp) begin
      m_phase++;
      if (m_phase == TB_DIV) begin
        m_phase = 0;
        e.tick  = 1'b1;
        m_q--;
        e.done  = (m_q == 0);
      end
    end
    e.q       = m_q[W-1:0];
    e.running = r && pp && (m_q != 0);
    e.id      = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle once the driver has issued a step
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (q !== mon_e.q) begin
          errors++;
          $display("FAIL q step %0d: got %0d expected %0d", mon_e.id, q, mon_e.q);
        end
        checks++;
        if (tick_1s !== mon_e.tick) begin
          errors++;
          $display("FAIL tick_1s step %0d: got %b expected %b", mon_e.id, tick_1s, mon_e.tick);
        end
        checks++;
        if (running !== mon_e.running) begin
          errors++;
          $display("FAIL running step %0d: got %b expected %b", mon_e.id, running, mon_e.running);
        end
        checks++;
        if (done !== mon_e.done) begin
          errors++;
          $display("FAIL done step %0d: got %b expected %b", mon_e.id, done, mon_e.done);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic         r, ld, pp;
    logic [W-1:0] pre;
    rst_n      = 1'b0;
    load       = 1'b0;
    play_pause = 1'b0;
    preset     = '0;
    @(posedge clk);
    #2;

    // Reset overrides a concurrent load
    repeat (3) step(1'b0, 1'b1, 1'b1, W'(7));
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);

    // Full countdown from 3
    step(1'b1, 1'b1, 1'b1, W'(3));
    repeat (16) step(1'b1, 1'b0, 1'b1, '0);

    // Pause with a fractional second pending, then resume
    step(1'b1, 1'b1, 1'b1, W'(5));
    repeat (6)  step(1'b1, 1'b0, 1'b1, '0);
    repeat (10) step(1'b1, 1'b0, 1'b0, '0);
    repeat (6)  step(1'b1, 1'b0, 1'b1, '0);

    // Reload mid-run with divider at DIV-1
    step(1'b1, 1'b1, 1'b1, W'(5));
    repeat (11) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, W'(2));
    repeat (6) step(1'b1, 1'b0, 1'b1, '0);

    // Load on the expiry edge suppresses done
    step(1'b1, 1'b1, 1'b1, W'(2));
    repeat (7) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, W'(3));
    repeat (14) step(1'b1, 1'b0, 1'b1, '0);

    // Zero preset stays idle
    step(1'b1, 1'b1, 1'b1, '0);
    repeat (20) step(1'b1, 1'b0, 1'b1, '0);

    // Reset mid-run requires a new load
    step(1'b1, 1'b1, 1'b1, W'(5));
    repeat (9) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    repeat (10) step(1'b1, 1'b0, 1'b1, '0);

    // Randomized traffic
    repeat (3000) begin
      r   = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      pp  = ($urandom_range(0, 3) != 0);
      pre = W'($urandom_range(0, 6));
      step(r, ld, pp, pre);
    end

    // Every issued expectation must have been consumed
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
